// File: rtl/clkdiv_bringup_seq.sv
// rtl/clkdiv_bringup_seq.sv - bring-up sequencer for a CLKDIV (DIV_MODE 4) in the audio clock path
//
// Waits for a stable PLL lock, holds and releases the divider reset, optionally
// pulses CALIB, measures the divided clock edge rate, and only then releases the
// downstream system reset. Lock loss and failed checks restart the sequence.
//
// Optional feature macro: CLKDIV_SEQ_CALIB_EN (builds the CALIB state).
//
// Ports:
//   hclkin      in   fast clock, same as CLKDIV HCLKIN
//   resetn      in   asynchronous active-low reset
//   pll_lock    in   PLL lock, asynchronous (2-FF synchronized)
//   clkout_mon  in   CLKDIV CLKOUT fed back (2-FF synchronized)
//   restart     in   single-cycle soft restart request
//   div_resetn  out  CLKDIV RESETN
//   div_calib   out  CLKDIV CALIB
//   sys_resetn  out  active-low reset for downstream audio logic
//   ready       out  divided clock verified and running
//   fault       out  retry limit exhausted
//   retry_cnt   out  count of failed verifications
//   state_dbg   out  current state encoding

module clkdiv_bringup_seq #(
  parameter int LOCK_STABLE_CYC = 1024,
  parameter int HOLD_CYC        = 16,
  parameter int SETTLE_CYC      = 64,
  parameter int DIV             = 4,
  parameter int VERIFY_WIN      = 64,
  parameter int MAX_RETRY       = 3,
  parameter int RW              = 2
) (
  input  logic          hclkin,
  input  logic          resetn,
  input  logic          pll_lock,
  input  logic          clkout_mon,
  input  logic          restart,
  output logic          div_resetn,
  output logic          div_calib,
  output logic          sys_resetn,
  output logic          ready,
  output logic          fault,
  output logic [RW-1:0] retry_cnt,
  output logic [2:0]    state_dbg
);

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_HOLD      = 3'd1,
    S_SETTLE    = 3'd2,
    S_CALIB     = 3'd3,
    S_VERIFY    = 3'd4,
    S_RUN       = 3'd5,
    S_FAULT     = 3'd6
  } state_t;

  // One shared timer serves every timed state, so size it for the longest one.
  localparam int MAX_A   = (LOCK_STABLE_CYC > HOLD_CYC) ? LOCK_STABLE_CYC : HOLD_CYC;
  localparam int MAX_B   = (SETTLE_CYC > VERIFY_WIN) ? SETTLE_CYC : VERIFY_WIN;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_STABLE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] WIN_LAST    = CW'(VERIFY_WIN - 1);

  localparam int RCW       = $clog2(VERIFY_WIN + 1) + 1;
  localparam int EXP_RISES = VERIFY_WIN / DIV;
  localparam logic [RCW-1:0] RISE_LO = RCW'((EXP_RISES > 0) ? EXP_RISES - 1 : 0);
  localparam logic [RCW-1:0] RISE_HI = RCW'(EXP_RISES + 1);
  localparam logic [RW-1:0]  RETRY_LIMIT = RW'(MAX_RETRY);

  logic [1:0]     lock_sync_q;
  logic [1:0]     mon_sync_q;
  logic           mon_prev_q;
  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [RCW-1:0] rise_q, rise_d, rise_sum;
  logic [RW-1:0]  retry_q, retry_d, retry_inc;
  logic           div_resetn_q, div_resetn_d;
  logic           sys_resetn_q, sys_resetn_d;
  logic           ready_q, ready_d;
  logic           fault_q, fault_d;
  logic           lock_s, mon_rise, win_pass;

  assign lock_s   = lock_sync_q[1];
  assign mon_rise = mon_sync_q[1] & ~mon_prev_q;

`ifdef CLKDIV_SEQ_CALIB_EN
  logic calib_done_q, calib_done_d;
  logic div_calib_q, div_calib_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    rise_d    = '0;
    retry_d   = retry_q;
`ifdef CLKDIV_SEQ_CALIB_EN
    calib_done_d = calib_done_q;
`endif
    // The rise that lands in the last window cycle still counts toward the result.
    rise_sum  = (rise_q == '1) ? rise_q : rise_q + RCW'(mon_rise);
    win_pass  = (rise_sum >= RISE_LO) && (rise_sum <= RISE_HI);
    retry_inc = (retry_q == '1) ? retry_q : retry_q + RW'(1);

    if (!lock_s && state_q != S_WAIT_LOCK && state_q != S_FAULT) begin
      state_d = S_WAIT_LOCK;
      cnt_d   = '0;
    end else if (restart && state_q != S_WAIT_LOCK && state_q != S_FAULT) begin
      // Wins over a window result in the same cycle, so no retry is charged.
      state_d = S_HOLD;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_WAIT_LOCK: begin
          if (!lock_s) begin
            cnt_d = '0;
          end else if (cnt_q == LOCK_LAST) begin
            state_d = S_HOLD;
            cnt_d   = '0;
          end
        end
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = S_SETTLE;
            cnt_d   = '0;
`ifdef CLKDIV_SEQ_CALIB_EN
            calib_done_d = 1'b0;
`endif
          end
        end
        S_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_d = '0;
`ifdef CLKDIV_SEQ_CALIB_EN
            state_d = calib_done_q ? S_VERIFY : S_CALIB;
`else
            state_d = S_VERIFY;
`endif
          end
        end
`ifdef CLKDIV_SEQ_CALIB_EN
        S_CALIB: begin
          state_d      = S_SETTLE;
          cnt_d        = '0;
          calib_done_d = 1'b1;
        end
`endif
        S_VERIFY: begin
          rise_d = rise_sum;
          if (cnt_q == WIN_LAST) begin
            cnt_d  = '0;
            rise_d = '0;
            if (win_pass) begin
              state_d = S_RUN;
            end else begin
              retry_d = retry_inc;
              state_d = (retry_inc >= RETRY_LIMIT) ? S_FAULT : S_HOLD;
            end
          end
        end
        S_RUN: begin
          cnt_d = '0;
        end
        S_FAULT: begin
          cnt_d = '0;
          if (restart) begin
            retry_d = '0;
            state_d = S_WAIT_LOCK;
          end
        end
        default: begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs follow the next state so they change together with state_q.
    div_resetn_d = (state_d == S_SETTLE) || (state_d == S_CALIB) ||
                   (state_d == S_VERIFY) || (state_d == S_RUN);
    sys_resetn_d = (state_d == S_RUN);
    ready_d      = (state_d == S_RUN);
    fault_d      = (state_d == S_FAULT);
`ifdef CLKDIV_SEQ_CALIB_EN
    div_calib_d  = (state_d == S_CALIB);
`endif
  end

  always_ff @(posedge hclkin or negedge resetn) begin
    if (!resetn) begin
      lock_sync_q  <= '0;
      mon_sync_q   <= '0;
      mon_prev_q   <= 1'b0;
      state_q      <= S_WAIT_LOCK;
      cnt_q        <= '0;
      rise_q       <= '0;
      retry_q      <= '0;
      div_resetn_q <= 1'b0;
      sys_resetn_q <= 1'b0;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      lock_sync_q  <= {lock_sync_q[0], pll_lock};
      mon_sync_q   <= {mon_sync_q[0], clkout_mon};
      mon_prev_q   <= mon_sync_q[1];
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rise_q       <= rise_d;
      retry_q      <= retry_d;
      div_resetn_q <= div_resetn_d;
      sys_resetn_q <= sys_resetn_d;
      ready_q      <= ready_d;
      fault_q      <= fault_d;
    end
  end

`ifdef CLKDIV_SEQ_CALIB_EN
  always_ff @(posedge hclkin or negedge resetn) begin
    if (!resetn) begin
      calib_done_q <= 1'b0;
      div_calib_q  <= 1'b0;
    end else begin
      calib_done_q <= calib_done_d;
      div_calib_q  <= div_calib_d;
    end
  end
  assign div_calib = div_calib_q;
`else
  assign div_calib = 1'b0;
`endif

  assign div_resetn = div_resetn_q;
  assign sys_resetn = sys_resetn_q;
  assign ready      = ready_q;
  assign fault      = fault_q;
  assign retry_cnt  = retry_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_clkdiv_bringup_seq.sv
// tb/tb_clkdiv_bringup_seq.sv - self-checking bench for clkdiv_bringup_seq

module tb_clkdiv_bringup_seq;

  logic       hclkin = 1'b0;
  logic       resetn = 1'b0;
  logic       pll_lock = 1'b0;
  logic       clkout_mon = 1'b0;
  logic       restart = 1'b0;
  logic       div_resetn, div_calib, sys_resetn, ready, fault;
  logic [1:0] retry_cnt;
  logic [2:0] state_dbg;

  clkdiv_bringup_seq #(
    .LOCK_STABLE_CYC(16),
    .HOLD_CYC(4),
    .SETTLE_CYC(8),
    .DIV(4),
    .VERIFY_WIN(32),
    .MAX_RETRY(3),
    .RW(2)
  ) dut (
    .hclkin(hclkin),
    .resetn(resetn),
    .pll_lock(pll_lock),
    .clkout_mon(clkout_mon),
    .restart(restart),
    .div_resetn(div_resetn),
    .div_calib(div_calib),
    .sys_resetn(sys_resetn),
    .ready(ready),
    .fault(fault),
    .retry_cnt(retry_cnt),
    .state_dbg(state_dbg)
  );

  always #5 hclkin = ~hclkin;

  typedef enum int {M_STUCK0, M_STUCK1, M_DIV, M_BURST} mode_e;
  typedef struct {
    mode_e mode;
    int    n;
    int    exp_state;
    int    exp_ready;
    int    exp_retry;
  } vec_t;
  typedef struct {
    int state;
    int ready;
    int retry;
  } exp_t;

  exp_t  sb_q[$];
  vec_t  vecs[9];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    exits = 0;
  mode_e mon_mode = M_STUCK0;
  int    mon_n = 4;
  int    ph = 0;
  int    b_idx = 1000;
  logic [2:0] drv_prev = 3'd0;
  logic [2:0] sb_prev = 3'd0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // clkout_mon generator: steady divide, stuck levels, or a burst of N
  // rises (period 3) launched at the start of each verify window.
  always @(negedge hclkin) begin
    case (mon_mode)
      M_STUCK0: clkout_mon = 1'b0;
      M_STUCK1: clkout_mon = 1'b1;
      M_DIV: begin
        ph = (ph + 1) % mon_n;
        clkout_mon = (ph < mon_n / 2);
      end
      M_BURST: begin
        if (state_dbg == 3'd4 && drv_prev != 3'd4) b_idx = 0;
        if (state_dbg == 3'd4 && b_idx < 3 * mon_n) begin
          clkout_mon = (b_idx % 3 == 0);
          b_idx++;
        end else begin
          clkout_mon = 1'b0;
        end
      end
      default: clkout_mon = 1'b0;
    endcase
    drv_prev = state_dbg;
  end

  // Scoreboard: every exit from VERIFY pops one expected outcome.
  always @(negedge hclkin) begin
    if (resetn && sb_prev == 3'd4 && state_dbg != 3'd4) begin
      exits++;
      if (sb_q.size() == 0) begin
        check("verify_exit_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("exit_state", int'(state_dbg), e.state);
        check("exit_ready", int'(ready), e.ready);
        check("exit_sys_resetn", int'(sys_resetn), e.ready);
        check("exit_retry", int'(retry_cnt), e.retry);
      end
    end
    sb_prev = state_dbg;
  end

  task automatic do_reset();
    @(negedge hclkin);
    #3 resetn = 1'b0;
    #1 check("reset_outputs",
             int'({state_dbg, div_resetn, div_calib, sys_resetn, ready, fault, retry_cnt}), 0);
    check("sb_drained", sb_q.size(), 0);
    sb_q.delete();
    pll_lock = 1'b0;
    restart  = 1'b0;
    repeat (2) @(negedge hclkin);
    resetn = 1'b1;
  endtask

  task automatic wait_exits(input int target, input int budget);
    int c;
    c = 0;
    while (exits < target && c < budget) begin
      @(negedge hclkin);
      c++;
    end
    check("exit_timeout", int'(exits >= target), 1);
  endtask

  task automatic wait_state(input int s, input int budget, output int cyc);
    cyc = 0;
    while (int'(state_dbg) != s && cyc < budget) begin
      @(negedge hclkin);
      cyc++;
    end
    check("state_timeout", int'(state_dbg), s);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int c;
    int t_div;
    int t_rdy;
    int t_cal;
    int cal_hi;

    // 32-cycle window, expected 8 rises, pass band 7..9.
    vecs[0] = '{M_DIV,    4,  5, 1, 0};
    vecs[1] = '{M_DIV,    2,  1, 0, 1};
    vecs[2] = '{M_DIV,    3,  1, 0, 1};
    vecs[3] = '{M_DIV,    8,  1, 0, 1};
    vecs[4] = '{M_BURST,  7,  5, 1, 0};
    vecs[5] = '{M_BURST,  9,  5, 1, 0};
    vecs[6] = '{M_BURST,  6,  1, 0, 1};
    vecs[7] = '{M_BURST, 10,  1, 0, 1};
    vecs[8] = '{M_STUCK1, 0,  1, 0, 1};

    for (int i = 0; i < 9; i++) begin
      do_reset();
      mon_mode = vecs[i].mode;
      mon_n    = (vecs[i].n > 0) ? vecs[i].n : 4;
      sb_q.push_back('{vecs[i].exp_state, vecs[i].exp_ready, vecs[i].exp_retry});
      base = exits;
      @(negedge hclkin);
      pll_lock = 1'b1;
      wait_exits(base + 1, 300);
      @(negedge hclkin);
      check("vec_fault", int'(fault), 0);
    end

    // Nominal bring-up timing, measured from the pll_lock drive.
    do_reset();
    mon_mode = M_DIV;
    mon_n    = 4;
    sb_q.push_back('{5, 1, 0});
    @(negedge hclkin);
    pll_lock = 1'b1;
    c = 0; t_div = -1; t_rdy = -1; t_cal = -1; cal_hi = 0;
    while (t_rdy < 0 && c < 300) begin
      @(negedge hclkin);
      c++;
      if (div_resetn && t_div < 0) t_div = c;
      if (div_calib) begin
        cal_hi++;
        t_cal = c;
      end
      if (ready) t_rdy = c;
    end
    check("nom_div_resetn_rise", t_div, 22);
`ifdef CLKDIV_SEQ_CALIB_EN
    check("nom_ready_rise", t_rdy, 71);
    check("nom_calib_pulses", cal_hi, 1);
    check("nom_calib_delay", t_cal - t_div, 8);
`else
    check("nom_ready_rise", t_rdy, 62);
    check("nom_calib_pulses", cal_hi, 0);
`endif
    check("nom_sys_resetn", int'(sys_resetn), 1);
    @(negedge hclkin);

    // Lock glitch in WAIT_LOCK restarts the stability count.
    do_reset();
    mon_mode = M_DIV;
    mon_n    = 4;
    sb_q.push_back('{5, 1, 0});
    base = exits;
    @(negedge hclkin);
    pll_lock = 1'b1;
    repeat (10) @(negedge hclkin);
    pll_lock = 1'b0;
    @(negedge hclkin);
    pll_lock = 1'b1;
    c = 0;
    while (state_dbg == 3'd0 && c < 100) begin
      @(negedge hclkin);
      c++;
    end
    check("glitch_hold_delay", c, 18);
    check("glitch_hold_state", int'(state_dbg), 1);
    wait_exits(base + 1, 200);

    // Stuck divider: three failures, FAULT, then restart.
    do_reset();
    mon_mode = M_STUCK0;
    sb_q.push_back('{1, 0, 1});
    sb_q.push_back('{1, 0, 2});
    sb_q.push_back('{6, 0, 3});
    base = exits;
    @(negedge hclkin);
    pll_lock = 1'b1;
    wait_exits(base + 3, 400);
    @(negedge hclkin);
    check("stuck_fault", int'(fault), 1);
    check("stuck_div_resetn", int'(div_resetn), 0);
    check("stuck_state", int'(state_dbg), 6);
    restart = 1'b1;
    @(negedge hclkin);
    restart = 1'b0;
    check("restart_state", int'(state_dbg), 0);
    check("restart_fault", int'(fault), 0);
    check("restart_retry", int'(retry_cnt), 0);
    wait_state(1, 40, c);

    // Wrong ratio then corrected divider.
    do_reset();
    mon_mode = M_DIV;
    mon_n    = 2;
    sb_q.push_back('{1, 0, 1});
    sb_q.push_back('{5, 1, 1});
    base = exits;
    @(negedge hclkin);
    pll_lock = 1'b1;
    wait_exits(base + 1, 200);
    mon_n = 4;
    wait_exits(base + 2, 200);

    // Lock loss in RUN, then full re-sequence.
    do_reset();
    mon_mode = M_DIV;
    mon_n    = 4;
    sb_q.push_back('{5, 1, 0});
    base = exits;
    @(negedge hclkin);
    pll_lock = 1'b1;
    wait_exits(base + 1, 200);
    @(negedge hclkin);
    pll_lock = 1'b0;
    c = 0;
    while (ready && c < 20) begin
      @(negedge hclkin);
      c++;
    end
    check("lockloss_delay", c, 3);
    check("lockloss_div_resetn", int'(div_resetn), 0);
    check("lockloss_sys_resetn", int'(sys_resetn), 0);
    check("lockloss_state", int'(state_dbg), 0);
    sb_q.push_back('{5, 1, 0});
    @(negedge hclkin);
    pll_lock = 1'b1;
    wait_exits(base + 2, 200);
    @(negedge hclkin);
    check("relock_ready", int'(ready), 1);

    // Restart in the last VERIFY cycle discards a failing result.
    do_reset();
    mon_mode = M_STUCK0;
    sb_q.push_back('{1, 0, 0});
    @(negedge hclkin);
    pll_lock = 1'b1;
    wait_state(4, 200, c);
    repeat (31) @(negedge hclkin);
    restart = 1'b1;
    @(negedge hclkin);
    restart = 1'b0;
    check("late_restart_state", int'(state_dbg), 1);
    check("late_restart_retry", int'(retry_cnt), 0);

    do_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clkdiv_bringup_seq.md
Name: clkdiv_bringup_seq

Overview:
- Sequences bring-up of the Gowin CLKDIV (DIV_MODE 4) in the audio clock path.
- Waits for a stable PLL lock, then holds and releases the divider reset.
- Optionally pulses CALIB, then checks the divided clock for the correct edge rate.
- Only after that check passes does it release a downstream system reset. Recovers from lock loss and retries failed checks up to a limit.

Parameters:
- LOCK_STABLE_CYC, 1024: consecutive synchronized lock-high cycles required before bring-up.
- HOLD_CYC, 16: cycles div_resetn is held low before release.
- SETTLE_CYC, 64: cycles waited after div_resetn release, and after CALIB.
- DIV, 4: expected divide ratio of the monitored clock.
- VERIFY_WIN, 64: measurement window in hclkin cycles; must be a multiple of DIV.
- MAX_RETRY, 3: failed verifications tolerated before FAULT.
- RW, 2: retry_cnt width; must satisfy 2^RW > MAX_RETRY.

Ports:
- hclkin  in  1  fast clock; the same clock that feeds CLKDIV HCLKIN.
- resetn  in  1  asynchronous active-low reset.
- pll_lock  in  1  PLL lock; asynchronous to hclkin; 2-FF synchronized internally.
- clkout_mon  in  1  CLKDIV CLKOUT, fed back for monitoring; 2-FF synchronized internally.
- restart  in  1  single-cycle soft restart request.
- div_resetn  out  1  drives CLKDIV RESETN.
- div_calib  out  1  drives CLKDIV CALIB.
- sys_resetn  out  1  active-low reset for the downstream audio logic.
- ready  out  1  divided clock verified and running.
- fault  out  1  retry limit exhausted.
- retry_cnt  out  RW  count of failed verifications.
- state_dbg  out  3  current state encoding.

Behaviour:
- Clock and reset: one clock, hclkin. Reset is asynchronous, active-low (resetn).
- Outputs while resetn=0: state=WAIT_LOCK. div_resetn=0, div_calib=0, sys_resetn=0, ready=0, fault=0, retry_cnt=0. All counters 0.
- Outputs are registered and take effect the cycle after the state decision.
- lock_s: pll_lock after 2 FFs. mon_s: clkout_mon after 2 FFs. A mon rise is mon_s=1 while the previous mon_s=0.
- State encodings: WAIT_LOCK=0, HOLD=1, SETTLE=2, CALIB=3, VERIFY=4, RUN=5, FAULT=6.
- WAIT_LOCK:
  - div_resetn=0, sys_resetn=0.
  - Stability counter increments while lock_s=1 and clears to 0 on lock_s=0.
  - On reaching LOCK_STABLE_CYC-1 with lock_s=1, go to HOLD.
- HOLD:
  - div_resetn=0 for HOLD_CYC cycles.
  - On exit: set div_resetn=1, clear the calib_done flag, go to SETTLE.
- SETTLE:
  - Wait SETTLE_CYC cycles.
  - With the macro defined and calib_done=0, go to CALIB; otherwise go to VERIFY.
- CALIB:
  - div_calib=1 for exactly one cycle.
  - Set calib_done=1, return to SETTLE.
- VERIFY:
  - Count mon rises over exactly VERIFY_WIN cycles; the counter saturates at its maximum.
  - Pass when the count is within VERIFY_WIN/DIV ±1. On pass, go to RUN.
  - On fail, increment retry_cnt (saturating). If the new value is ≥ MAX_RETRY, go to FAULT; otherwise go to HOLD, which re-asserts div_resetn=0.
- RUN: sys_resetn=1 and ready=1, both asserted on the cycle after entry.
- FAULT:
  - fault=1; div_resetn=0, sys_resetn=0, ready=0.
  - Exits only on restart (clears retry_cnt, goes to WAIT_LOCK) or on reset.
- Lock loss: lock_s=0 in any state except WAIT_LOCK or FAULT goes to WAIT_LOCK on the next cycle. div_resetn, sys_resetn and ready drop that same cycle. retry_cnt is kept. A VERIFY window in progress is abandoned.
- restart outside FAULT: goes to HOLD and drops sys_resetn/ready. It is ignored in WAIT_LOCK.
- Priority, highest first: reset, then lock loss, then restart, then normal transitions (verification result and timer expiry). restart in the last VERIFY cycle discards the result; retry_cnt is not incremented.
- Reset mid-operation returns immediately to the reset values above; no partial window result is kept.

Optional Feature:
- CLKDIV_SEQ_CALIB_EN defined: the CALIB state is reachable. Exactly one div_calib pulse per HOLD→VERIFY pass, followed by a second SETTLE_CYC wait.
- Not defined: div_calib is tied to 0, the CALIB state is not built, and SETTLE always goes to VERIFY.

Test Plan:
- Nominal bring-up. Params LOCK_STABLE_CYC=16, HOLD_CYC=4, SETTLE_CYC=8, VERIFY_WIN=32, DIV=4, macro off. Raise pll_lock and drive clkout_mon as hclkin/4. Required: div_resetn rises about 20 cycles after lock_s; 8 mon rises counted; ready=sys_resetn=1 roughly 62 cycles after the pll_lock rise; retry_cnt=0.
- Lock glitch in WAIT_LOCK. A 1-cycle pll_lock low after 10 high cycles -> stability counter restarts; HOLD entered only after 16 further consecutive lock cycles.
- Stuck divider. clkout_mon held at 0, MAX_RETRY=3 -> three VERIFY failures, retry_cnt goes 1, 2, 3, then fault=1 and div_resetn=0. A restart pulse then clears fault and retry_cnt, and the block re-enters WAIT_LOCK.
- Wrong ratio. clkout_mon at hclkin/2 -> 16 rises counted, outside 7..9 -> verification fails and retry_cnt=1. Switching to /4 before the next window -> RUN.
- Lock loss in RUN. pll_lock drops -> ready, sys_resetn and div_resetn all 0 by lock_s+1 cycle; state_dbg=0; full re-sequence after lock returns.
- Macro on. One nominal pass -> exactly one div_calib high cycle, SETTLE_CYC cycles after the div_resetn rise; VERIFY starts SETTLE_CYC cycles after that pulse.
